// File: rtl/full_adder.sv
// Registered 3:2 compressor row: WIDTH independent full adders, sum/carry
// captured one cycle after a valid input, carry kept at the input bit index.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic k
);
  assign s = a ^ b ^ c;
  assign k = (a & b) | (a & c) | (b & c);
endmodule

module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             out_valid
);
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] k;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_bit u_bit (
      .a(a[i]),
      .b(b[i]),
      .c(c[i]),
      .s(s[i]),
      .k(k[i])
    );
  end

  // Data only loads on valid, so X on idle inputs never reaches the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= '0;
      carry     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum   <= s;
        carry <= k;
      end
    end
  end
endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder: a WIDTH=8 row and a WIDTH=1 cell share
// stimulus (the single-bit cell sees bit 0); checks run on the falling edge.
module tb_full_adder;
  typedef struct {
    logic [7:0] a, b, c;
    logic [7:0] s, k;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] a = '0, b = '0, c = '0;
  logic [7:0] s8, k8;
  logic       v8;
  logic [0:0] s1, k1;
  logic       v1;
  int         tests = 0;
  int         fails = 0;
  exp_t       q[$];

  always #5 clk = ~clk;

  full_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c),
    .sum(s8), .carry(k8), .out_valid(v8)
  );

  full_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a[0:0]), .b(b[0:0]), .c(c[0:0]),
    .sum(s1), .carry(k1), .out_valid(v1)
  );

  // Reference: per-bit integer add, split into low (sum) and high (carry) bit.
  function automatic exp_t mk(input logic [7:0] ta, input logic [7:0] tb, input logic [7:0] tc);
    exp_t e;
    e.a = ta; e.b = tb; e.c = tc;
    for (int i = 0; i < 8; i++) begin
      int t;
      t = int'(ta[i]) + int'(tb[i]) + int'(tc[i]);
      e.s[i] = t[0];
      e.k[i] = t[1];
    end
    return e;
  endfunction

  task automatic drive(input logic v, input logic [7:0] ta, input logic [7:0] tb, input logic [7:0] tc);
    in_valid = v; a = ta; b = tb; c = tc;
    if (v) q.push_back(mk(ta, tb, tc));
  endtask

  task automatic test_reset;
    @(negedge clk);
    tests++;
    if ({v8, s8, k8, v1, s1, k1} !== '0) begin
      fails++; $display("FAIL reset_init got v8=%b s8=%h k8=%h v1=%b s1=%b k1=%b want all 0", v8, s8, k8, v1, s1, k1);
    end
    // valid input presented across an edge while rst is held must be dropped
    in_valid = 1'b1; a = 8'hFF; b = 8'hFF; c = 8'h00;
    @(negedge clk);
    tests++;
    if ({v8, s8, k8, v1, s1, k1} !== '0) begin
      fails++; $display("FAIL reset_discard got v8=%b s8=%h k8=%h want all 0", v8, s8, k8);
    end
    rst = 1'b0; drive(1'b0, 8'h00, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    tests++;
    if ({v8, s8, k8, v1, s1, k1} !== '0) begin
      fails++; $display("FAIL reset_release got v8=%b s8=%h k8=%h want all 0", v8, s8, k8);
    end
  endtask

  task automatic test_truth_table;
    logic [2:0] tt [8];
    logic [1:0] sk [8];
    tt = '{3'b000, 3'b001, 3'b010, 3'b101, 3'b100, 3'b111, 3'b110, 3'b011};
    sk = '{2'b00,  2'b10,  2'b10,  2'b01,  2'b10,  2'b11,  2'b01,  2'b01};
    q.delete();
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        tests++;
        if ({v1, s1, k1} !== {1'b1, sk[i-1]}) begin
          fails++; $display("FAIL truth_%b got v=%b s=%b k=%b want v=1 s=%b k=%b", tt[i-1], v1, s1, k1, sk[i-1][1], sk[i-1][0]);
        end
      end
      if (i < 8) drive(1'b1, {7'd0, tt[i][2]}, {7'd0, tt[i][1]}, {7'd0, tt[i][0]});
      else drive(1'b0, 8'h00, 8'h00, 8'h00);
      @(negedge clk);
    end
    q.delete();
  endtask

  task automatic test_hold;
    drive(1'b1, 8'hFF, 8'hFF, 8'hFF);
    @(negedge clk);
    tests++;
    if ({v8, s8, k8, v1, s1, k1} !== {1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1}) begin
      fails++; $display("FAIL hold_load got v8=%b s8=%h k8=%h v1=%b s1=%b k1=%b want 1 ff ff 1 1 1", v8, s8, k8, v1, s1, k1);
    end
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    tests++;
    if ({v8, s8, k8, v1, s1, k1} !== {1'b0, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1}) begin
      fails++; $display("FAIL hold_idle got v8=%b s8=%h k8=%h v1=%b s1=%b k1=%b want 0 ff ff 0 1 1", v8, s8, k8, v1, s1, k1);
    end
    in_valid = 1'b0; a = 'x; b = 'z; c = 'x;
    repeat (2) @(negedge clk);
    tests++;
    if ({v8, s8, k8, v1, s1, k1} !== {1'b0, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1}) begin
      fails++; $display("FAIL hold_xz got v8=%b s8=%h k8=%h v1=%b s1=%b k1=%b want 0 ff ff 0 1 1", v8, s8, k8, v1, s1, k1);
    end
    q.delete();
  endtask

  task automatic test_width8;
    exp_t e;
    drive(1'b1, 8'hF0, 8'hCC, 8'hAA);
    @(negedge clk);
    q.delete();
    tests++;
    if ({v8, s8, k8} !== {1'b1, 8'h96, 8'hE8}) begin
      fails++; $display("FAIL w8_fixed got v=%b s=%h k=%h want v=1 s=96 k=e8", v8, s8, k8);
    end
    for (int n = 0; n <= 1000; n++) begin
      if (n > 0) begin
        if (q.size() == 0) begin
          tests++; fails++; $display("FAIL w8_rand_%0d scoreboard empty", n);
        end else begin
          e = q.pop_front();
          tests++;
          if ({v8, s8, k8, v1, s1, k1} !== {1'b1, e.s, e.k, 1'b1, e.s[0], e.k[0]}) begin
            fails++; $display("FAIL w8_rand_%0d a=%h b=%h c=%h got s=%h k=%h s1=%b k1=%b want s=%h k=%h", n, e.a, e.b, e.c, s8, k8, s1, k1, e.s, e.k);
          end
          for (int i = 0; i < 8; i++) begin
            tests++;
            if (int'(e.a[i]) + int'(e.b[i]) + int'(e.c[i]) != int'(s8[i]) + 2 * int'(k8[i])) begin
              fails++; $display("FAIL w8_invariant_%0d bit %0d got s=%b k=%b for a=%b b=%b c=%b", n, i, s8[i], k8[i], e.a[i], e.b[i], e.c[i]);
            end
          end
        end
      end
      if (n < 1000) drive(1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
      else drive(1'b0, 8'h00, 8'h00, 8'h00);
      @(negedge clk);
    end
    q.delete();
  endtask

  task automatic test_midstream_reset;
    exp_t e;
    drive(1'b1, 8'hFF, 8'h00, 8'h00);
    @(negedge clk);
    e = q.pop_front();
    tests++;
    if ({v8, s8, k8} !== {1'b1, e.s, e.k}) begin
      fails++; $display("FAIL mid_pre got v=%b s=%h k=%h want v=1 s=%h k=%h", v8, s8, k8, e.s, e.k);
    end
    drive(1'b1, 8'h0F, 8'h33, 8'h55);
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({v8, s8, k8, v1, s1, k1} !== '0) begin
      fails++; $display("FAIL mid_async got v8=%b s8=%h k8=%h v1=%b want all 0", v8, s8, k8, v1);
    end
    #1 rst = 1'b0;
    q.delete();
    q.push_back(mk(8'h0F, 8'h33, 8'h55));
    @(negedge clk);
    e = q.pop_front();
    tests++;
    if ({v8, s8, k8, v1, s1, k1} !== {1'b1, e.s, e.k, 1'b1, e.s[0], e.k[0]}) begin
      fails++; $display("FAIL mid_first got v=%b s=%h k=%h want v=1 s=%h k=%h", v8, s8, k8, e.s, e.k);
    end
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   vcnt = 0;
    for (int n = 0; n <= 16; n++) begin
      if (n > 0) begin
        e = q.pop_front();
        if (v8 === 1'b1) vcnt++;
        tests++;
        if ({v8, s8, k8, v1, s1, k1} !== {1'b1, e.s, e.k, 1'b1, e.s[0], e.k[0]}) begin
          fails++; $display("FAIL b2b_%0d got v=%b s=%h k=%h want v=1 s=%h k=%h", n, v8, s8, k8, e.s, e.k);
        end
      end
      if (n < 16) drive(1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
      else drive(1'b0, 8'h00, 8'h00, 8'h00);
      @(negedge clk);
    end
    tests++;
    if (vcnt != 16 || v8 !== 1'b0) begin
      fails++; $display("FAIL b2b_count got valid_cycles=%0d trailing_v=%b want 16 and 0", vcnt, v8);
    end
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_hold();
    test_width8();
    test_midstream_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
